// File: rtl/wb_master_ctrl.sv
// Single-outstanding Wishbone classic-cycle initiator driven by a valid/ready command port.
// Optional REQ-state timeout abort is compiled in with `define WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [15:0] i_cmd_adr,
    input  logic [15:0] i_cmd_data,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_busy,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [15:0] o_wb_adr,
    output logic [15:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [15:0] i_wb_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    state_t      state_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        busy_q;
    logic        cyc_q;
    logic        stb_q;
    logic        we_q;
    logic [15:0] adr_q;
    logic [15:0] wdata_q;

`ifdef WB_MASTER_TIMEOUT_EN
    logic             rsp_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_s;

    // Counter arithmetic kept outside the FSM so the compare/increment are explicit.
    always_comb begin
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        timeout_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    assign o_rsp_err = rsp_err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    // Command/bus/response FSM; every output is a register updated here.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            busy_q      <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 16'h0000;
            wdata_q     <= 16'h0000;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        state_q     <= ST_REQ;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        we_q        <= i_cmd_we;
                        adr_q       <= i_cmd_adr;
                        wdata_q     <= i_cmd_data;
`ifdef WB_MASTER_TIMEOUT_EN
                        cnt_q       <= {CNT_W{1'b0}};
`endif
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout landing on the same edge.
                    if (i_wb_ack) begin
                        state_q     <= ST_RSP;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= we_q ? 16'h0000 : i_wb_data;
`ifdef WB_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (timeout_s) begin
                        state_q     <= ST_RSP;
                        cyc_q       <= 1'b0;
                        stb_q       <= 1'b0;
                        we_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= 16'h0000;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        cnt_q       <= cnt_d;
`endif
                    end
                end
                ST_RSP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_data_q  <= 16'h0000;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
                    rsp_err_q   <= 1'b0;
`endif
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cyc_q       <= 1'b0;
                    stb_q       <= 1'b0;
                    we_q        <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_busy      = busy_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = we_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_data   = wdata_q;

endmodule
